// File: rtl/serializador_pkg.sv
// Shared constants for the serializador bit-serial transmitter.
package serializador_pkg;

  // One-bit state encoding, kept as plain constants for legacy compatibility.
  localparam logic [0:0] REPOSO = 1'b0;
  localparam logic [0:0] ENVIO  = 1'b1;

  // Default word width.
  localparam int N_DEF = 8;

endpackage

// File: rtl/serializador_if.sv
// Load/serial-stream bundle between a word producer and the serializador.
interface serializador_if
  import serializador_pkg::*;
#(
  parameter int N = N_DEF
);

  logic         carga;
  logic [N-1:0] d;
  logic         listo;
  logic         q;
  logic         valido;
  logic         fin;

  // Producer side: offers words and watches the serial stream.
  modport master (output carga, d, input listo, q, valido, fin);

  // Transmitter side: takes words and produces the serial stream.
  modport slave  (input carga, d, output listo, q, valido, fin);

endinterface

// File: rtl/serializador_contador_bajada.sv
// Loadable down-counter with a zero flag; counts the bits left in a word.
module contador_bajada #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cargar,
  input  logic         dec,
  input  logic [W-1:0] valor,
  output logic [W-1:0] cnt,
  output logic         cero
);

  // Load has priority over decrement; reset clears the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (cargar) begin
      cnt <= valor;
    end else if (dec) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign cero = (cnt == '0);

endmodule

// File: rtl/serializador.sv
// Parallel-in/serial-out transmitter: shifts an N-bit word out MSB first,
// one bit per clock, with valid strobe and end-of-word pulse.
module serializador
  import serializador_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic         clk,
  input  logic         reset,
  serializador_if.slave bus
);

  localparam int            CW     = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

  logic [0:0]    estado;
  logic [N-1:0]  sr;
  logic [CW-1:0] cnt;
  logic          cero;
  logic          enviando;
  logic          listo_i;
  logic          acepta;

  assign enviando = (estado == ENVIO);
  // Free while idle, or during the last bit so the next word follows with no gap.
  assign listo_i  = !enviando || cero;
  assign acepta   = bus.carga && listo_i;

  // Outputs depend only on registered state, never on carga/d.
  assign bus.listo  = listo_i;
  assign bus.valido = enviando;
  assign bus.q      = enviando && sr[N-1];
  assign bus.fin    = enviando && cero;

  // Bits remaining after the one currently on q; held at zero while idle.
  contador_bajada #(.W(CW)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .cargar (acepta),
    .dec    (enviando && !cero),
    .valor  (ULTIMO),
    .cnt    (cnt),
    .cero   (cero)
  );

  // State: enter ENVIO on an accepted word, drop to REPOSO after an unfollowed last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      estado <= REPOSO;
    end else if (acepta) begin
      estado <= ENVIO;
    end else if (enviando && cero) begin
      estado <= REPOSO;
    end
  end

  // Shift register: capture the word on acceptance, otherwise move the next bit to the MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr <= '0;
    end else if (acepta) begin
      sr <= bus.d;
    end else if (enviando) begin
      sr <= sr << 1;
    end
  end

endmodule

// File: tb/tb_serializador.sv
// Self-checking bench for serializador: directed scenarios plus random
// traffic against a queue-of-pending-bits reference model.
module tb_serializador;

  localparam int N8 = 8;
  localparam int N2 = 2;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serializador_if #(.N(N8)) b8 ();
  serializador_if #(.N(N2)) b2 ();

  serializador #(.N(N8)) dut8 (.clk(clk), .reset(rst_n), .bus(b8.slave));
  serializador #(.N(N2)) dut2 (.clk(clk), .reset(rst_n), .bus(b2.slave));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: each entry is {is_last_bit, bit} still to be sent; the
  // front entry is what the line shows in the current cycle.
  logic [1:0] m8[$];
  logic [1:0] m2[$];

  function automatic logic [3:0] exp8();
    if (m8.size() == 0) return 4'b1000;
    return {m8.size() == 1, 1'b1, m8[0][1], m8[0][0]};
  endfunction

  function automatic logic [3:0] exp2();
    if (m2.size() == 0) return 4'b1000;
    return {m2.size() == 1, 1'b1, m2[0][1], m2[0][0]};
  endfunction

  // Advance the model across the coming rising edge using the inputs now driven.
  task automatic step_model();
    bit acc;
    if (!rst_n) begin
      m8.delete();
      m2.delete();
      return;
    end
    acc = b8.carga && (m8.size() <= 1);
    if (m8.size() > 0) void'(m8.pop_front());
    if (acc) for (int k = N8 - 1; k >= 0; k--) m8.push_back({k == 0, b8.d[k]});
    acc = b2.carga && (m2.size() <= 1);
    if (m2.size() > 0) void'(m2.pop_front());
    if (acc) for (int k = N2 - 1; k >= 0; k--) m2.push_back({k == 0, b2.d[k]});
  endtask

  task automatic test_reset();
    logic [3:0] obs;
    rst_n = 1'b0;
    b8.carga = 1'b0; b8.d = '0;
    b2.carga = 1'b0; b2.d = '0;
    step_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {b8.listo, b8.valido, b8.fin, b8.q};
      n_cmp++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_hold: got %b want 1000", obs);
      end
      step_model();
    end
    rst_n = 1'b1;
    step_model();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {b8.listo, b8.valido, b8.fin, b8.q};
      n_cmp++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL reset_release: got %b want 1000", obs);
      end
      step_model();
    end
  endtask

  // One word, explicit per-bit expectation {listo,valido,fin,q}.
  task automatic test_single_word(input logic [7:0] word, input string name);
    logic [3:0] obs, exp;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        obs = {b8.listo, b8.valido, b8.fin, b8.q};
        exp = (i <= 8) ? {i == 8, 1'b1, i == 8, word[8 - i]} : 4'b1000;
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL %s cyc%0d: got %b want %b", name, i, obs, exp);
        end
      end
      b8.carga = (i == 0);
      b8.d     = (i == 0) ? word : 8'h00;
      step_model();
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    logic [3:0]  obs, exp;
    stream = 16'hF00F;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (i > 0) begin
        obs = {b8.listo, b8.valido, b8.fin, b8.q};
        exp = (i <= 16) ? {i == 8 || i == 16, 1'b1, i == 8 || i == 16, stream[16 - i]}
                        : 4'b1000;
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL back_to_back cyc%0d: got %b want %b", i, obs, exp);
        end
      end
      b8.carga = (i == 0) || (i == 8);
      b8.d     = (i == 0) ? 8'hF0 : 8'h0F;
      step_model();
    end
  endtask

  task automatic test_ignored_load();
    logic [7:0] word;
    logic [3:0] obs, exp;
    word = 8'h81;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i > 0) begin
        obs = {b8.listo, b8.valido, b8.fin, b8.q};
        exp = (i <= 8) ? {i == 8, 1'b1, i == 8, word[8 - i]} : 4'b1000;
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL ignored_load cyc%0d: got %b want %b", i, obs, exp);
        end
      end
      b8.carga = (i == 0) || (i == 3);
      b8.d     = (i == 0) ? word : 8'hFF;
      step_model();
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] word;
    logic [3:0] obs, exp;
    word = 8'hC3;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) begin
        obs = {b8.listo, b8.valido, b8.fin, b8.q};
        exp = {1'b0, 1'b1, 1'b0, word[8 - i]};
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL mid_reset_pre cyc%0d: got %b want %b", i, obs, exp);
        end
      end
      if (i < 5) begin
        b8.carga = (i == 0);
        b8.d     = word;
        step_model();
      end
    end
    b8.carga = 1'b0;
    #2;
    rst_n = 1'b0;
    step_model();
    #1;
    obs = {b8.listo, b8.valido, b8.fin, b8.q};
    n_cmp++;
    if (obs !== 4'b1000) begin
      n_err++;
      $display("FAIL mid_reset_async: got %b want 1000", obs);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      step_model();
    end
    rst_n = 1'b1;
    step_model();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      obs = {b8.listo, b8.valido, b8.fin, b8.q};
      n_cmp++;
      if (obs !== 4'b1000) begin
        n_err++;
        $display("FAIL mid_reset_after cyc%0d: got %b want 1000", i, obs);
      end
      step_model();
    end
  endtask

  task automatic test_n2();
    logic [1:0] word;
    logic [3:0] obs, exp;
    word = 2'b10;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        obs = {b2.listo, b2.valido, b2.fin, b2.q};
        exp = (i <= 2) ? {i == 2, 1'b1, i == 2, word[2 - i]} : 4'b1000;
        n_cmp++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL n2_word cyc%0d: got %b want %b", i, obs, exp);
        end
      end
      b2.carga = (i == 0);
      b2.d     = word;
      step_model();
    end
    b2.carga = 1'b0;
  endtask

  task automatic test_random();
    logic [3:0] obs, exp;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      obs = {b8.listo, b8.valido, b8.fin, b8.q};
      exp = exp8();
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL random_n8 cyc%0d: got %b want %b", i, obs, exp);
      end
      obs = {b2.listo, b2.valido, b2.fin, b2.q};
      exp = exp2();
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL random_n2 cyc%0d: got %b want %b", i, obs, exp);
      end
      b8.carga = ($urandom_range(0, 3) != 0);
      b8.d     = 8'($urandom);
      b2.carga = ($urandom_range(0, 2) == 0);
      b2.d     = 2'($urandom);
      step_model();
    end
    b8.carga = 1'b0;
    b2.carga = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      step_model();
    end
  endtask

  initial begin
    test_reset();
    test_single_word(8'hA5, "word_a5");
    test_back_to_back();
    test_ignored_load();
    test_mid_reset();
    test_n2();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serializador.md
# serializador

Parallel-in/serial-out transmitter. Accepts an N-bit word through the same `carga`/`d` load convention as the team's load-enabled flip-flop and shifts it out MSB first, one bit per clock, with a valid strobe and an end-of-word pulse. It is the sending end of the bit-serial link between register stages; the matching deserializer rebuilds words from the `q`/`valido` stream.

## Interface
- `N`, default 8: word width in bits; legal range 2..32.
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low; asserting it (0) immediately forces the reset state; released synchronously to `clk` by the system.
- `carga`  input  1  load request; a word is accepted only on an edge where `carga && listo`.
- `d`  input  N  parallel word, sampled on the accepting edge.
- `listo`  output  1  block can accept a word this cycle.
- `q`  output  1  serial data bit.
- `valido`  output  1  `q` carries a valid bit this cycle.
- `fin`  output  1  high during the cycle carrying the last bit (`d[0]`) of a word.

## Operation
- Two states: `REPOSO` (idle) and `ENVIO` (shifting). Internal N-bit shift register `sr` and down-counter `cnt`, width `$clog2(N)`.
- Reset values: state `REPOSO`, `sr`=0, `cnt`=0. Outputs: `q`=0, `valido`=0, `fin`=0, `listo`=1.
- `REPOSO`: `listo`=1, `valido`=0, `q`=0. On `carga`: `sr`<=`d`, `cnt`<=N-1, go to `ENVIO`.
- `ENVIO`: `valido`=1, `q`=`sr[N-1]`. Each edge: `sr`<=`sr`<<1, `cnt`<=`cnt`-1.
- Last bit: `cnt`==0 in `ENVIO` means `fin`=1 and `listo`=1.
  - Edge with `carga`=1: load the new word, set `cnt`<=N-1, stay in `ENVIO`. Back-to-back words have no gap.
  - Edge with `carga`=0: go to `REPOSO`.
- `carga` while `listo`=0 is ignored; `d` is not sampled and the word in flight is not disturbed.
- `carga` held high continuously: a new word is accepted on every last-bit edge.
- `reset` asserted mid-word aborts the word at once. Outputs take reset values asynchronously. No partial-word completion after release.
- `listo`, `valido`, `fin`, `q` are decoded from registered state only. No combinational path from `carga`/`d` to any output.

## Timing
- Latency: word accepted on edge t, so `d[N-1]` appears on `q` with `valido`=1 in the cycle after edge t.
- Bit `d[N-1-k]` is on `q` in cycle t+1+k, k=0..N-1. `fin`=1 in cycle t+N only.
- Throughput: one word per N cycles when back-to-back. Single isolated word: `valido` high for exactly N cycles.
- Sequential logic uses non-blocking assignments. Output decode is combinational from state.

## Structure
- Shared package/header: state encoding localparams `REPOSO`=1'b0, `ENVIO`=1'b1, and default `N`.
- Width of `cnt` is derived locally from `N`. Nothing else is shared.
- One natural sub-module: `contador_bajada`, a loadable down-counter with a zero flag and async active-low reset. The shift register and state bit stay inline.

## Test plan
- Reset: hold `reset`=0 for 3 cycles, then release -> `listo`=1, `valido`=0, `q`=0, `fin`=0 throughout and after.
- N=8, `d`=8'hA5, one-cycle `carga` -> `q` = 1,0,1,0,0,1,0,1 on 8 consecutive cycles with `valido`=1; `fin` only on the 8th; `listo`=1 from the 9th.
- Back-to-back: 8'hF0 then 8'h0F, second `carga` on the `fin` cycle -> 16 contiguous valid bits 11110000 00001111, no gap, `fin` on bits 8 and 16.
- Ignored load: `carga` with 8'hFF during bit 3 of 8'h81 -> stream stays 10000001; 8'hFF never appears.
- Mid-word reset: drop `reset` during bit 5 of 8'hC3 -> `valido`, `q`, `fin` go 0 immediately (same cycle, before the next edge); after release, idle with `listo`=1 until a new `carga`.
- N=2 instance, `d`=2'b10 -> `q` = 1,0, `fin` on the 2nd bit, then idle.
